// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axi_lite_pkg;

    // AXI response code
    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } arb_state_t;

    // Protection attribute driven on both AW and AR: unprivileged, secure, data
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning upward and wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W:0]   sum_w [N];
    logic [IDX_W-1:0] cand  [N];

    // cand[k] is the requester index examined at search offset k from ptr
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign sum_w[gi] = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum_w[gi] >= (IDX_W+1)'(N))
                             ? IDX_W'(sum_w[gi] - (IDX_W+1)'(N))
                             : sum_w[gi][IDX_W-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit to ptr wins
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (enable && req[cand[k]]) begin
                grant_idx = cand[k];
                any       = 1'b1;
            end
        end
        if (any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters, round-robin,
// with exactly one transaction in flight at a time.
module axi_lite_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    import axi_lite_pkg::*;

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    arb_state_t              state_reg,   state_next;
    logic [IDX_W-1:0]        ptr_reg,     ptr_next;
    logic [IDX_W-1:0]        gidx_reg,    gidx_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,   wdata_next;
    logic [STRB_W-1:0]       wstrb_reg,   wstrb_next;
    logic                    awvalid_reg, awvalid_next;
    logic                    wvalid_reg,  wvalid_next;
    logic                    arvalid_reg, arvalid_next;
    logic [DATA_WIDTH-1:0]   rdata_reg,   rdata_next;
    axi_resp_t               resp_reg,    resp_next;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]       wstrb_arr [NUM_REQ];

    logic [NUM_REQ-1:0]      grant_onehot;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    arb_enable;

    // Unpack the flattened requester buses and decode the response strobe
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
            assign rsp_valid[gi] = (state_reg == DONE) && (gidx_reg == IDX_W'(gi));
        end
    endgenerate

    // Grants are only offered while idle and out of reset, so req_ready
    // is a clean one-cycle pulse that never fires during reset
    assign arb_enable = (state_reg == IDLE) && !areset;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req          (req_valid),
        .ptr          (ptr_reg),
        .enable       (arb_enable),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    assign req_ready     = grant_onehot;
    assign rsp_rdata     = rdata_reg;
    assign rsp_resp      = resp_reg;

    assign m_axi_awaddr  = addr_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_bready  = (state_reg == WR_RESP);
    assign m_axi_rready  = (state_reg == RD_DATA);

    // Next-state and capture logic for the transaction sequencer
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gidx_next    = gidx_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        arvalid_next = arvalid_reg;
        rdata_next   = rdata_reg;
        resp_next    = resp_reg;

        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    gidx_next  = grant_idx;
                    addr_next  = addr_arr[grant_idx];
                    wdata_next = wdata_arr[grant_idx];
                    wstrb_next = wstrb_arr[grant_idx];
                    if (req_write[grant_idx]) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_ADDR;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are done
                if (awvalid_reg && m_axi_awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && m_axi_wready) begin
                    wvalid_next = 1'b0;
                end
                if (!awvalid_next && !wvalid_next) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    resp_next  = m_axi_bresp;
                    rdata_next = '0;
                    state_next = DONE;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_next = m_axi_rdata;
                    resp_next  = m_axi_rresp;
                    state_next = DONE;
                end
            end
            DONE: begin
                ptr_next   = (gidx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gidx_reg    <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= RESP_OKAY;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gidx_reg    <= gidx_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            arvalid_reg <= arvalid_next;
            rdata_reg   <= rdata_next;
            resp_reg    <= resp_next;
        end
    end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Shares one AXI4-Lite master port among NUM_REQ local requesters, e.g. the CPU-side config bus, the DMA sequencer and the debug port targeting the interrupt register block.
- Round-robin arbitration; one outstanding transaction at a time.
- Each requester sees a simple request/response interface; the block sequences the AW/W/B and AR/R phases.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, AXI data width (32 or 64).
- ADDR_WIDTH, 5, AXI address width.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request strobe; held until req_ready.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_wstrb  in  NUM_REQ*DATA_WIDTH/8  flattened byte strobes.
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request captured.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction complete.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid; shared by all requesters.
- rsp_resp  out  2  AXI response code; valid with rsp_valid.
- m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid, m_axi_awready: AXI4-Lite write-address channel, master side.
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready: write-data channel.
- m_axi_bresp(2), m_axi_bvalid, m_axi_bready: write-response channel.
- m_axi_araddr, m_axi_arprot(3), m_axi_arvalid, m_axi_arready: read-address channel.
- m_axi_rdata, m_axi_rresp(2), m_axi_rvalid, m_axi_rready: read-data channel.

Behaviour:
- Reset: FSM goes to IDLE and the round-robin pointer to 0.
  - All valids, readies and pulses reset to 0.
  - Address, data, rsp_rdata and rsp_resp registers reset to 0.
  - awprot and arprot are constant 3'b000.
- Reset mid-transaction aborts immediately; no response is issued.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - Round-robin search starts at the pointer, in ascending index, wrapping modulo NUM_REQ.
  - On a hit at index g: register g, write, addr, wdata and wstrb; pulse req_ready[g] in that same cycle.
  - Write goes to WR with awvalid = wvalid = 1 next cycle; read goes to RD_ADDR with arvalid = 1 next cycle.
  - Grant latency: request to AXI valid is 1 cycle.
- WR:
  - awvalid and wvalid are asserted together; the downstream slave requires both before accepting.
  - Each valid drops independently on its own handshake (valid & ready).
  - Go to WR_RESP when both have completed, including completion in the same cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp into rsp_resp, set rsp_rdata = 0, go to DONE.
- RD_ADDR: arvalid held until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to DONE.
- DONE:
  - rsp_valid[g] = 1 for exactly one cycle; no backpressure.
  - Pointer = (g+1) mod NUM_REQ.
  - Go to IDLE; the next grant is evaluated in the following cycle.
- Arbitration boundaries:
  - Requests arriving during a transaction wait.
  - Simultaneous requests are granted in pointer order.
  - A single persistent requester is re-granted every transaction: 1 idle cycle between transactions.
- Slave errors (resp 2'b10/2'b11) are forwarded unchanged; no retry.
- No timeout; a hung slave stalls the arbiter until reset.
- A requester dropping req_valid before req_ready is legal; it is simply not granted.
- rsp_rdata and rsp_resp hold their value until the next capture.

Decomposition:
- Package axi_lite_pkg:
  - typedef axi_resp_t (2 bits) with constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - enum arb_state_t with the six states.
  - constant PROT_DEFAULT = 3'b000.
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr, enable; outputs grant_onehot[N], grant_idx, any. Combinational priority rotate; the pointer register stays in the parent.
- The remainder (FSM, capture registers, AXI channel drivers) lives in axi_lite_req_arbiter.

Test Plan:
- Single write:
  - Stimulus: NUM_REQ = 2; requester 0 writes addr 0x04, data 0xDEADBEEF, wstrb 0xF.
  - Required: req_ready[0] pulses; awvalid and wvalid next cycle with awaddr 0x04, wdata 0xDEADBEEF.
  - Required: after bvalid with bresp 00, rsp_valid[0] is 1 cycle with rsp_resp 00.
- Single read:
  - Stimulus: requester 1 reads addr 0x08; slave returns rdata 0x00000005, rresp 00.
  - Required: rsp_valid[1] with rsp_rdata 0x00000005.
  - Required: arvalid holds while arready is stalled for 3 cycles.
- Contention:
  - Stimulus: requesters 0 and 1 both assert continuously from reset.
  - Required: grants alternate 0,1,0,1; no requester is granted twice in a row.
- Split write handshake:
  - Stimulus: slave raises awready 2 cycles before wready.
  - Required: awvalid drops after its handshake; wvalid stays high until wready; exactly one B phase.
  - Required: same-cycle awready and wready also completes correctly.
- Error forwarding:
  - Stimulus: slave returns bresp 2'b10.
  - Required: rsp_resp = 2'b10 and the arbiter returns to IDLE.
- Reset mid-transaction:
  - Stimulus: areset is asserted during RD_DATA.
  - Required: next cycle all valids and readies are 0, no rsp_valid, pointer 0; a new request then proceeds normally.
